// File: rtl/mem_arb_pkg.sv
// Shared types and address-map constants for the unified-memory arbiter.
package mem_arb_pkg;

    localparam int          ADDR_W_DEF    = 14;
    localparam logic [13:0] DMEM_BASE_DEF = 14'h2000;
    localparam logic [13:0] PMEM_END      = 14'h1FFF;
    localparam logic [13:0] DMEM_END      = 14'h3FFF;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_sel_t;

    typedef enum logic {
        FSRC_IF = 1'b0,
        FSRC_D  = 1'b1
    } fault_src_t;

endpackage

// File: rtl/mem_arb_region_chk.sv
// Combinational address-map legality check for one (port, address) pair.
module mem_arb_region_chk
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] DMEM_BASE = DMEM_BASE_DEF
) (
    input  fault_src_t        port,
    input  logic [ADDR_W-1:0] addr,
    output logic              legal
);

    // Program region is fetch-only, data region is data-only.
    always_comb begin
        legal = 1'b0;
        if (port == FSRC_D) legal = (addr >= DMEM_BASE);
        else                legal = (addr <  DMEM_BASE);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-port unified memory with sticky region-fault capture.
// Optional macro MEM_ARB_STARVE_GUARD_EN lets a starved fetch port win over D priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W       = 14,
    parameter int                DATA_W       = 16,
    parameter logic [ADDR_W-1:0] DMEM_BASE    = DMEM_BASE_DEF,
    parameter int                STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fault_valid,
    output logic              fault_src,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              fault_clr
);

    logic              force_if;
    logic              any_gnt_p0;
    fault_src_t        win_src_p0;
    logic [ADDR_W-1:0] win_addr_p0;
    logic              win_legal_p0;
    logic              fault_new_p0;

    resp_sel_t         resp_sel_p1;
    logic              resp_err_p1;
    logic              resp_rd_p1;

    fault_src_t        fault_src_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign force_if = (starve_cnt == CNT_W'(STARVE_LIMIT)) && if_req && d_req;

    always_ff @(posedge clk) begin
        if (rst || !if_req || if_gnt) starve_cnt <= '0;
        else if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign force_if = 1'b0;
`endif

    // Stage p0: arbitration and region check on the winner, memory strobe in the grant cycle.
    // Grants are held off during reset so nothing reaches memory or the response pipe.
    assign d_gnt  = !rst && d_req && !force_if;
    assign if_gnt = !rst && if_req && !d_gnt;

    assign any_gnt_p0  = d_gnt || if_gnt;
    assign win_src_p0  = d_gnt ? FSRC_D : FSRC_IF;
    assign win_addr_p0 = d_gnt ? d_addr : if_addr;

    mem_arb_region_chk #(
        .ADDR_W   (ADDR_W),
        .DMEM_BASE(DMEM_BASE)
    ) u_region_chk (
        .port (win_src_p0),
        .addr (win_addr_p0),
        .legal(win_legal_p0)
    );

    assign fault_new_p0 = any_gnt_p0 && !win_legal_p0;

    assign mem_en    = any_gnt_p0 && win_legal_p0;
    assign mem_we    = mem_en && d_gnt && d_we;
    assign mem_addr  = any_gnt_p0 ? win_addr_p0 : '0;
    assign mem_wdata = any_gnt_p0 ? d_wdata : '0;

    // Stage p1: registered response select; read data comes straight from memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_sel_p1 <= RESP_NONE;
            resp_err_p1 <= 1'b0;
            resp_rd_p1  <= 1'b0;
        end else begin
            resp_sel_p1 <= d_gnt ? RESP_D : (if_gnt ? RESP_IF : RESP_NONE);
            resp_err_p1 <= fault_new_p0;
            resp_rd_p1  <= mem_en && !mem_we;
        end
    end

    // Gating by rst drops a response that was scheduled just before reset.
    assign if_rvalid = !rst && (resp_sel_p1 == RESP_IF);
    assign d_rvalid  = !rst && (resp_sel_p1 == RESP_D);
    assign if_err    = if_rvalid && resp_err_p1;
    assign d_err     = d_rvalid && resp_err_p1;
    assign if_rdata  = (if_rvalid && resp_rd_p1) ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && resp_rd_p1) ? mem_rdata : '0;

    // A new fault wins over a simultaneous clear so it is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_valid <= 1'b0;
            fault_src_q <= FSRC_IF;
            fault_addr  <= '0;
        end else if (fault_new_p0 && (!fault_valid || fault_clr)) begin
            fault_valid <= 1'b1;
            fault_src_q <= win_src_p0;
            fault_addr  <= win_addr_p0;
        end else if (fault_clr) begin
            fault_valid <= 1'b0;
        end
    end

    assign fault_src = fault_src_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a simple registered-read memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [13:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [15:0] if_rdata;
    logic        d_req, d_we;
    logic [13:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [15:0] d_rdata;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        fault_valid, fault_src, fault_clr;
    logic [13:0] fault_addr;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_model [0:16383];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fault_valid(fault_valid), .fault_src(fault_src),
        .fault_addr(fault_addr), .fault_clr(fault_clr)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            mem_rdata <= mem_model[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem_model[i] = 16'h0000;
        mem_model[14'h0010] = 16'hBEEF;
        mem_model[14'h0020] = 16'h5A5A;
        mem_model[14'h2004] = 16'h1234;
        mem_model[14'h2010] = 16'h7777;
        mem_rdata = 16'h0000;
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; fault_clr = 0;
        @(negedge clk); tick();
        rst = 1'b0;
        #1;
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_fault_valid", fault_valid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);

        // single fetch
        @(negedge clk);
        if_req = 1; if_addr = 14'h0010;
        #1;
        check("t1_if_gnt", if_gnt, 1);
        check("t1_d_gnt", d_gnt, 0);
        check("t1_mem_en", mem_en, 1);
        check("t1_mem_addr", mem_addr, 14'h0010);
        check("t1_mem_we", mem_we, 0);
        tick();
        if_req = 0;
        #1;
        check("t1_if_rvalid", if_rvalid, 1);
        check("t1_if_rdata", if_rdata, 16'hBEEF);
        check("t1_if_err", if_err, 0);
        check("t1_d_rvalid", d_rvalid, 0);

        // simultaneous requests: D first, IF next
        @(negedge clk);
        if_req = 1; if_addr = 14'h0020;
        d_req = 1; d_we = 0; d_addr = 14'h2004;
        #1;
        check("t2_d_gnt", d_gnt, 1);
        check("t2_if_gnt", if_gnt, 0);
        check("t2_mem_addr", mem_addr, 14'h2004);
        tick();
        d_req = 0;
        #1;
        check("t2_d_rvalid", d_rvalid, 1);
        check("t2_d_rdata", d_rdata, 16'h1234);
        check("t2_if_rvalid_early", if_rvalid, 0);
        check("t2_if_gnt_next", if_gnt, 1);
        check("t2_mem_addr_next", mem_addr, 14'h0020);
        tick();
        if_req = 0;
        #1;
        check("t2_if_rvalid", if_rvalid, 1);
        check("t2_if_rdata", if_rdata, 16'h5A5A);
        check("t2_d_rvalid_late", d_rvalid, 0);

        // D store into program region faults
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 14'h0100; d_wdata = 16'hFFFF;
        #1;
        check("t3_d_gnt", d_gnt, 1);
        check("t3_mem_en", mem_en, 0);
        check("t3_mem_we", mem_we, 0);
        tick();
        d_req = 0; d_we = 0;
        #1;
        check("t3_d_rvalid", d_rvalid, 1);
        check("t3_d_err", d_err, 1);
        check("t3_d_rdata", d_rdata, 0);
        check("t3_fault_valid", fault_valid, 1);
        check("t3_fault_src", fault_src, 1);
        check("t3_fault_addr", fault_addr, 14'h0100);
        check("t3_mem_untouched", mem_model[14'h0100], 0);

        // IF fetch from data region: error response, fault register unchanged
        if_req = 1; if_addr = 14'h3000;
        #1;
        check("t3b_if_gnt", if_gnt, 1);
        check("t3b_mem_en", mem_en, 0);
        tick();
        if_req = 0;
        #1;
        check("t3b_if_rvalid", if_rvalid, 1);
        check("t3b_if_err", if_err, 1);
        check("t3b_if_rdata", if_rdata, 0);
        check("t3b_fault_addr_kept", fault_addr, 14'h0100);
        check("t3b_fault_src_kept", fault_src, 1);

        // clear coinciding with new fault: new one captured
        fault_clr = 1; if_req = 1; if_addr = 14'h2100;
        tick();
        fault_clr = 0; if_req = 0;
        #1;
        check("t4_fault_valid", fault_valid, 1);
        check("t4_fault_addr", fault_addr, 14'h2100);
        check("t4_fault_src", fault_src, 0);
        fault_clr = 1;
        tick();
        fault_clr = 0;
        #1;
        check("t4_fault_cleared", fault_valid, 0);

        // legal store then readback
        d_req = 1; d_we = 1; d_addr = 14'h2008; d_wdata = 16'hCAFE;
        #1;
        check("t5_mem_en", mem_en, 1);
        check("t5_mem_we", mem_we, 1);
        check("t5_mem_wdata", mem_wdata, 16'hCAFE);
        tick();
        d_we = 0;
        #1;
        check("t5_st_rvalid", d_rvalid, 1);
        check("t5_st_rdata", d_rdata, 0);
        check("t5_st_err", d_err, 0);
        tick();
        d_req = 0;
        #1;
        check("t5_ld_rdata", d_rdata, 16'hCAFE);

        // both requesting continuously
        if_req = 1; if_addr = 14'h0020;
        d_req = 1; d_we = 0; d_addr = 14'h2010;
        for (int i = 0; i < 10; i++) begin
            #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
            check("t6_if_gnt", if_gnt, (i % 5 == 4) ? 1 : 0);
            check("t6_d_gnt", d_gnt, (i % 5 == 4) ? 0 : 1);
`else
            check("t6_if_gnt", if_gnt, 0);
            check("t6_d_gnt", d_gnt, 1);
`endif
            tick();
        end
        if_req = 0; d_req = 0;
        tick();

        // reset right after a faulting grant
        d_req = 1; d_we = 1; d_addr = 14'h0050; d_wdata = 16'h1111;
        #1;
        check("t7_d_gnt", d_gnt, 1);
        tick();
        d_req = 0; d_we = 0; rst = 1;
        #1;
        check("t7_rst_d_rvalid", d_rvalid, 0);
        check("t7_rst_d_err", d_err, 0);
        tick();
        rst = 0;
        #1;
        check("t7_post_fault_valid", fault_valid, 0);
        check("t7_post_fault_addr", fault_addr, 0);
        check("t7_post_d_rvalid", d_rvalid, 0);
        check("t7_post_if_rvalid", if_rvalid, 0);
        check("t7_post_mem_en", mem_en, 0);
        if_req = 1; if_addr = 14'h0010;
        #1;
        check("t7_fresh_if_gnt", if_gnt, 1);
        tick();
        if_req = 0;
        #1;
        check("t7_fresh_if_rdata", if_rdata, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port unified memory between the processor's instruction-fetch port (IF) and its load/store data port (D).
- Enforces the address map: program region 0x0000–0x1FFF is fetch-only; data region 0x2000–0x3FFF is data-only.
- Returns read data one cycle after the grant.
- Latches the first illegal access in a sticky fault register.

Parameters:
- ADDR_W, 14, memory address width (word-addressed, 16-bit words)
- DATA_W, 16, data width
- DMEM_BASE, 14'h2000, first data-region address; addresses below it are the program region
- STARVE_LIMIT, 4, consecutive denied IF cycles before IF is forced to win (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch response valid
- if_rdata  out  DATA_W  fetch data
- if_err  out  1  fetch response is a region fault
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  data response valid (loads and stores)
- d_rdata  out  DATA_W  load data; 0 for stores and faults
- d_err  out  1  data response is a region fault
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en
- fault_valid  out  1  sticky fault present
- fault_src  out  1  0 = IF, 1 = D
- fault_addr  out  ADDR_W  address of the first faulting access
- fault_clr  in  1  clears the sticky fault

Behaviour:
- Reset: every registered output is 0, the response pipeline is empty and the starvation counter is 0. A response scheduled before reset is dropped, so no rvalid appears in the cycle after reset.
- Arbitration in cycle T:
  - If only one port requests, that port is granted.
  - If both request, D wins (strict priority). The optional feature can override this.
  - At most one gnt per cycle. A request is sampled (addr/we/wdata) only in its grant cycle.
- Region check on the granted request:
  - IF is legal iff if_addr < DMEM_BASE.
  - D is legal iff d_addr >= DMEM_BASE.
- Legal grant in T: mem_en=1, mem_addr=granted addr, mem_we=d_we for D and 0 for IF, mem_wdata=d_wdata.
- Illegal grant in T: mem_en=0 and mem_we=0. Memory is never written from the wrong region.
- Response in T+1 (registered response select and error flag):
  - The granted port's rvalid=1.
  - rdata=mem_rdata for legal reads. rdata=0 for stores and faults.
  - err=1 for faults.
  - The non-granted port sees rvalid=0 and rdata=0.
- Back-to-back grants are allowed every cycle, giving a throughput of 1 access per cycle.
- Idle (no grant): mem_en=0, and mem_addr/mem_wdata hold 0.
- Fault register:
  - Captures src and addr on the first fault while fault_valid=0.
  - Later faults are ignored until fault_clr.
  - fault_clr in the same cycle as a new fault: the new fault is captured and fault_valid stays 1.
- Starvation counter:
  - Increments in cycles where if_req=1 and if_gnt=0.
  - Resets to 0 on if_gnt or when if_req=0.
  - Saturates at STARVE_LIMIT.

Optional Feature:
- MEM_ARB_STARVE_GUARD_EN defined: when the counter equals STARVE_LIMIT and both ports request, IF wins that cycle and the counter clears.
- Undefined: strict D priority, and the counter logic is removed (no counter flops).

Decomposition:
- Package mem_arb_pkg holds:
  - DMEM_BASE default and region-end constants
  - typedef resp_sel_t (RESP_NONE, RESP_IF, RESP_D)
  - typedef fault_src_t (FSRC_IF, FSRC_D)
- One sub-module, mem_arb_region_chk: combinational legality check of (port, addr). It is instantiated once, on the winner.

Test Plan:
- if_req with addr 0x0010, memory holds 0xBEEF -> if_gnt in T, mem_en=1 and mem_addr=0x0010 in T; if_rvalid=1 and if_rdata=0xBEEF in T+1.
- if_req and d_req (load 0x2004) in the same cycle -> d_gnt in T and if_gnt in T+1; responses arrive in T+1 and T+2 respectively.
- d_req store to 0x0100 -> mem_en=0 and mem_we=0; d_rvalid=1 and d_err=1 in T+1; fault_valid=1, fault_src=1, fault_addr=0x0100; a later IF fault to 0x3000 leaves the fault register unchanged.
- Fault pending, then fault_clr in the same cycle as a new fault (IF to 0x2100) -> fault_valid stays 1 with fault_addr=0x2100 and fault_src=0.
- With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, both requesting continuously -> four D grants, then one IF grant, repeating. Without the macro, IF is never granted.
- Grant in T, rst asserted in T+1 -> no rvalid in T+1; all outputs 0 in T+2; a fresh request after rst deasserts is granted normally.
